// File: rtl/coeff_loader_pkg.sv
// Shared constants and types for the coefficient bank loader.
// Frame bytes, ack codes, register map and the parser output bundle.
package coeff_loader_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_COMMIT = 8'h02;

    localparam logic [2:0] ACK_OK      = 3'd0;
    localparam logic [2:0] ACK_BADCSUM = 3'd1;
    localparam logic [2:0] ACK_BADADDR = 3'd2;
    localparam logic [2:0] ACK_BADCMD  = 3'd3;
    localparam logic [2:0] ACK_TIMEOUT = 3'd4;

    localparam int NUM_REGS    = 53;
    localparam int MEAN_BASE   = 44;
    localparam int STD_BASE    = 48;
    localparam int LIMIT_ADDR  = 52;
    localparam int SECTION_LEN = 11;
    localparam int BANK_W      = LIMIT_ADDR * 32;

    typedef enum logic [3:0] {
        ST_HUNT,
        ST_CMD,
        ST_ADDR,
        ST_D3,
        ST_D2,
        ST_D1,
        ST_D0,
        ST_CSUM,
        ST_EXEC
    } parse_state_e;

    // Decoded frame, valid for the single EXEC cycle.
    typedef struct packed {
        logic        valid;
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [2:0]  code;
    } frame_t;

    // Register index of coefficient i (0..10) of section s (1..4).
    function automatic logic [7:0] coeff_addr(input logic [2:0] section,
                                              input logic [3:0] index);
        return 8'(({5'd0, section} - 8'd1) * 8'(SECTION_LEN)
                  + {4'd0, index});
    endfunction

endpackage

// File: rtl/coeff_frame_parser.sv
// Byte-stream frame parser: sync hunt, field capture, checksum, timeout.
// Emits one decoded frame strobe per complete frame in its EXEC cycle.
module coeff_frame_parser
    import coeff_loader_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 1000
) (
    input  logic       sys_clk_i,
    input  logic       reset_i,
    input  logic [7:0] byte_i,
    input  logic       byte_fire_i,
    output frame_t     frame_o,
    output logic       timeout_o,
    output logic       exec_next_o
);

    localparam int TMO_W = $clog2(BYTE_TIMEOUT + 1);

    parse_state_e state_q, state_d;
    logic [7:0]   cmd_q, cmd_d;
    logic [7:0]   addr_q, addr_d;
    logic [31:0]  data_q, data_d;
    logic [7:0]   csum_q, csum_d;
    logic         csum_ok_q, csum_ok_d;
    logic [TMO_W-1:0] timer_q, timer_d;
    logic         in_frame;
    logic         timeout;

    assign in_frame = (state_q != ST_HUNT) && (state_q != ST_EXEC);

    // Next-state, field capture, running checksum and inter-byte timer.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        csum_d    = csum_q;
        csum_ok_d = csum_ok_q;
        timeout   = 1'b0;
        if (!in_frame || byte_fire_i) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 1'b1;
        end
        case (state_q)
            ST_HUNT: begin
                if (byte_fire_i && byte_i == SYNC_BYTE) begin
                    state_d = ST_CMD;
                    csum_d  = 8'h00;
                end
            end
            ST_CMD: begin
                if (byte_fire_i) begin
                    cmd_d   = byte_i;
                    csum_d  = csum_q ^ byte_i;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (byte_fire_i) begin
                    addr_d  = byte_i;
                    csum_d  = csum_q ^ byte_i;
                    state_d = ST_D3;
                end
            end
            ST_D3, ST_D2, ST_D1, ST_D0: begin
                if (byte_fire_i) begin
                    data_d  = {data_q[23:0], byte_i};
                    csum_d  = csum_q ^ byte_i;
                    state_d = parse_state_e'(state_q + 4'd1);
                end
            end
            ST_CSUM: begin
                if (byte_fire_i) begin
                    csum_ok_d = (byte_i == csum_q);
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_HUNT;
            default: state_d = ST_HUNT;
        endcase
        if (in_frame && !byte_fire_i
            && timer_q == TMO_W'(BYTE_TIMEOUT - 1)) begin
            timeout = 1'b1;
            state_d = ST_HUNT;
            timer_d = '0;
        end
    end

    // Parser state registers.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q   <= ST_HUNT;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            csum_q    <= '0;
            csum_ok_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            csum_q    <= csum_d;
            csum_ok_q <= csum_ok_d;
            timer_q   <= timer_d;
        end
    end

    // Decoded frame and result code, checksum first, then command, then address.
    always_comb begin
        frame_o.valid = (state_q == ST_EXEC);
        frame_o.cmd   = cmd_q;
        frame_o.addr  = addr_q;
        frame_o.data  = data_q;
        if (!csum_ok_q) begin
            frame_o.code = ACK_BADCSUM;
        end else if (cmd_q != CMD_WRITE && cmd_q != CMD_COMMIT) begin
            frame_o.code = ACK_BADCMD;
        end else if (cmd_q == CMD_WRITE && addr_q >= 8'(NUM_REGS)) begin
            frame_o.code = ACK_BADADDR;
        end else begin
            frame_o.code = ACK_OK;
        end
    end

    assign timeout_o   = timeout;
    assign exec_next_o = (state_d == ST_EXEC);

endmodule

// File: rtl/coeff_bank_loader.sv
// Shadow/active coefficient banks with in-flight-safe atomic commit.
// Frames come from coeff_frame_parser; all outputs are registered.
module coeff_bank_loader
    import coeff_loader_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 1000,
    parameter int INFLIGHT_W   = 4
) (
    input  logic          sys_clk_i,
    input  logic          reset_i,
    input  logic [7:0]    byte_i,
    input  logic          byte_valid_i,
    output logic          byte_ready_o,
    input  logic          adc_srdyi_i,
    input  logic          adc_srdyo_i,
    output logic [1663:0] coeff_bank_o,
    output logic [19:0]   section_limit_o,
    output logic          ack_valid_o,
    output logic [2:0]    ack_code_o,
    output logic          commit_done_o,
    output logic          commit_pending_o
);

    frame_t frame;
    logic   timeout;
    logic   exec_next;
    logic   byte_fire;

    logic [31:0] shadow_q [LIMIT_ADDR];
    logic [31:0] shadow_d [LIMIT_ADDR];
    logic [31:0] active_q [LIMIT_ADDR];
    logic [31:0] active_d [LIMIT_ADDR];
    logic [19:0] shadow_limit_q, shadow_limit_d;
    logic [19:0] active_limit_q, active_limit_d;

    logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
    logic pending_q, pending_d;
    logic done_q, done_d;
    logic ack_valid_q, ack_valid_d;
    logic [2:0] ack_code_q, ack_code_d;
    logic ready_q, ready_d;

    logic wr_ok;
    logic commit_req;
    logic copy;

    assign byte_fire = byte_valid_i && ready_q;

    coeff_frame_parser #(
        .BYTE_TIMEOUT(BYTE_TIMEOUT)
    ) u_parser (
        .sys_clk_i  (sys_clk_i),
        .reset_i    (reset_i),
        .byte_i     (byte_i),
        .byte_fire_i(byte_fire),
        .frame_o    (frame),
        .timeout_o  (timeout),
        .exec_next_o(exec_next)
    );

    assign wr_ok = frame.valid && frame.code == ACK_OK
                   && frame.cmd == CMD_WRITE;
    assign commit_req = frame.valid && frame.code == ACK_OK
                        && frame.cmd == CMD_COMMIT;

    // Shadow writes, commit arbitration against in-flight samples, acks.
    always_comb begin
        shadow_d       = shadow_q;
        shadow_limit_d = shadow_limit_q;
        active_d       = active_q;
        active_limit_d = active_limit_q;
        for (int k = 0; k < LIMIT_ADDR; k++) begin
            if (wr_ok && frame.addr == 8'(k)) begin
                shadow_d[k] = frame.data;
            end
        end
        if (wr_ok && frame.addr == 8'(LIMIT_ADDR)) begin
            shadow_limit_d = frame.data[19:0];
        end
        copy = (pending_q || commit_req) && inflight_q == '0
               && !adc_srdyi_i;
        if (copy) begin
            active_d       = shadow_q;
            active_limit_d = shadow_limit_q;
        end
        pending_d   = (pending_q || commit_req) && !copy;
        done_d      = copy;
        ack_valid_d = frame.valid || timeout;
        ack_code_d  = timeout ? ACK_TIMEOUT
                    : (frame.valid ? frame.code : ACK_OK);
        ready_d     = !exec_next && !pending_d;
    end

    // In-flight sample count, saturating at all-ones and floored at zero.
    always_comb begin
        inflight_d = inflight_q;
        if (adc_srdyi_i && !adc_srdyo_i && inflight_q != '1) begin
            inflight_d = inflight_q + 1'b1;
        end else if (adc_srdyo_i && !adc_srdyi_i && inflight_q != '0) begin
            inflight_d = inflight_q - 1'b1;
        end
    end

    // Bank, counter and output registers.
    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < LIMIT_ADDR; k++) begin
                shadow_q[k] <= '0;
                active_q[k] <= '0;
            end
            shadow_limit_q <= '0;
            active_limit_q <= '0;
            inflight_q     <= '0;
            pending_q      <= 1'b0;
            done_q         <= 1'b0;
            ack_valid_q    <= 1'b0;
            ack_code_q     <= '0;
            ready_q        <= 1'b0;
        end else begin
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            shadow_limit_q <= shadow_limit_d;
            active_limit_q <= active_limit_d;
            inflight_q     <= inflight_d;
            pending_q      <= pending_d;
            done_q         <= done_d;
            ack_valid_q    <= ack_valid_d;
            ack_code_q     <= ack_code_d;
            ready_q        <= ready_d;
        end
    end

    for (genvar g = 0; g < LIMIT_ADDR; g++) begin : g_bank
        assign coeff_bank_o[32*g +: 32] = active_q[g];
    end

    assign section_limit_o  = active_limit_q;
    assign byte_ready_o     = ready_q;
    assign ack_valid_o      = ack_valid_q;
    assign ack_code_o       = ack_code_q;
    assign commit_done_o    = done_q;
    assign commit_pending_o = pending_q;

endmodule

// File: tb/tb_coeff_bank_loader.sv
// Self-checking bench for coeff_bank_loader.
// Frame-level reference model: shadow/active arrays and an in-flight count.
module tb_coeff_bank_loader;

    localparam int TB_TIMEOUT = 1000;
    localparam int INF_MAX    = 15;

    logic          sys_clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic [7:0]    byte_i = 8'h00;
    logic          byte_valid_i = 1'b0;
    logic          byte_ready_o;
    logic          adc_srdyi_i = 1'b0;
    logic          adc_srdyo_i = 1'b0;
    logic [1663:0] coeff_bank_o;
    logic [19:0]   section_limit_o;
    logic          ack_valid_o;
    logic [2:0]    ack_code_o;
    logic          commit_done_o;
    logic          commit_pending_o;

    int vec = 0;
    int miscmp = 0;

    logic [31:0] m_shadow [53];
    logic [31:0] m_active [53];
    int          m_inflight = 0;
    bit          m_pending = 0;

    coeff_bank_loader #(
        .BYTE_TIMEOUT(TB_TIMEOUT),
        .INFLIGHT_W  (4)
    ) dut (
        .sys_clk_i       (sys_clk_i),
        .reset_i         (reset_i),
        .byte_i          (byte_i),
        .byte_valid_i    (byte_valid_i),
        .byte_ready_o    (byte_ready_o),
        .adc_srdyi_i     (adc_srdyi_i),
        .adc_srdyo_i     (adc_srdyo_i),
        .coeff_bank_o    (coeff_bank_o),
        .section_limit_o (section_limit_o),
        .ack_valid_o     (ack_valid_o),
        .ack_code_o      (ack_code_o),
        .commit_done_o   (commit_done_o),
        .commit_pending_o(commit_pending_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    function automatic logic [1663:0] exp_bank();
        logic [1663:0] b;
        for (int k = 0; k < 52; k++) b[32*k +: 32] = m_active[k];
        return b;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 53; k++) begin
            m_shadow[k] = '0;
            m_active[k] = '0;
        end
        m_inflight = 0;
        m_pending  = 0;
    endfunction

    task automatic tick();
        @(posedge sys_clk_i);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        n = 0;
        if (gap) repeat ($urandom_range(0, 2)) tick();
        while (!byte_ready_o && n < 50) begin
            tick();
            n++;
        end
        if (!byte_ready_o) begin
            miscmp++;
            vec++;
            $display("FAIL ready_wait: byte_ready_o=%b required 1", byte_ready_o);
        end
        byte_i = b;
        byte_valid_i = 1'b1;
        tick();
        byte_valid_i = 1'b0;
    endtask

    task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr,
                            input logic [31:0] d, input logic [7:0] cs_xor,
                            input string name);
        logic [7:0] cs;
        logic [2:0] code_exp;
        logic [2:0] code_got;
        int lat;
        int done_lat;
        bit got;
        bit commit_now;
        cs = cmd ^ addr ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0] ^ cs_xor;
        send_byte(8'hA5, 1);
        send_byte(cmd, 1);
        send_byte(addr, 1);
        send_byte(d[31:24], 1);
        send_byte(d[23:16], 1);
        send_byte(d[15:8], 1);
        send_byte(d[7:0], 1);
        send_byte(cs, 1);
        if (cs_xor != 0) code_exp = 3'd1;
        else if (cmd != 8'h01 && cmd != 8'h02) code_exp = 3'd3;
        else if (cmd == 8'h01 && addr > 8'd52) code_exp = 3'd2;
        else code_exp = 3'd0;
        lat = 0;
        done_lat = 0;
        got = 0;
        code_got = 3'bx;
        while (!got && lat < 8) begin
            tick();
            lat++;
            if (commit_done_o && done_lat == 0) done_lat = lat;
            if (ack_valid_o) begin
                got = 1;
                code_got = ack_code_o;
            end
        end
        vec++;
        if (!got || lat != 1) begin
            miscmp++;
            $display("FAIL %s ack_latency: got %0d (seen=%0d) required 1", name, lat, got);
        end
        vec++;
        if (code_got !== code_exp) begin
            miscmp++;
            $display("FAIL %s ack_code: got %0d required %0d", name, code_got, code_exp);
        end
        commit_now = 0;
        if (code_exp == 3'd0 && cmd == 8'h01) m_shadow[addr] = d;
        if (code_exp == 3'd0 && cmd == 8'h02) begin
            if (m_inflight == 0) begin
                m_active = m_shadow;
                commit_now = 1;
            end else begin
                m_pending = 1;
            end
        end
        vec++;
        if ((done_lat == 1) != commit_now) begin
            miscmp++;
            $display("FAIL %s commit_done: got cycle %0d required pulse=%0d", name, done_lat, commit_now);
        end
        vec++;
        if (commit_pending_o !== m_pending || byte_ready_o !== !m_pending) begin
            miscmp++;
            $display("FAIL %s pending/ready: got %b/%b required %b/%b", name,
                     commit_pending_o, byte_ready_o, m_pending, !m_pending);
        end
        vec++;
        if (coeff_bank_o !== exp_bank()) begin
            miscmp++;
            $display("FAIL %s coeff_bank: bank differs from model", name);
        end
        vec++;
        if (section_limit_o !== m_active[52][19:0]) begin
            miscmp++;
            $display("FAIL %s section_limit: got %h required %h", name,
                     section_limit_o, m_active[52][19:0]);
        end
    endtask

    task automatic engine_cycle(input bit si, input bit so, input string name);
        bit exp_copy;
        exp_copy = m_pending && m_inflight == 0 && !si;
        adc_srdyi_i = si;
        adc_srdyo_i = so;
        tick();
        adc_srdyi_i = 1'b0;
        adc_srdyo_i = 1'b0;
        if (si && !so && m_inflight < INF_MAX) m_inflight++;
        if (so && !si && m_inflight > 0) m_inflight--;
        if (exp_copy) begin
            m_active = m_shadow;
            m_pending = 0;
        end
        vec++;
        if (commit_done_o !== exp_copy || commit_pending_o !== m_pending) begin
            miscmp++;
            $display("FAIL %s engine_cycle: done/pending got %b/%b required %b/%b", name,
                     commit_done_o, commit_pending_o, exp_copy, m_pending);
        end
        vec++;
        if (coeff_bank_o !== exp_bank() || byte_ready_o !== !m_pending) begin
            miscmp++;
            $display("FAIL %s engine_bank: bank_ok=%b ready=%b required ready %b", name,
                     coeff_bank_o === exp_bank(), byte_ready_o, !m_pending);
        end
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        repeat (3) tick();
        model_reset();
        vec++;
        if (ack_valid_o !== 0 || ack_code_o !== 0 || commit_done_o !== 0
            || commit_pending_o !== 0 || byte_ready_o !== 0) begin
            miscmp++;
            $display("FAIL reset_outputs: ack=%b code=%0d done=%b pend=%b ready=%b required all 0",
                     ack_valid_o, ack_code_o, commit_done_o, commit_pending_o, byte_ready_o);
        end
        vec++;
        if (coeff_bank_o !== '0 || section_limit_o !== '0) begin
            miscmp++;
            $display("FAIL reset_bank: bank nonzero or limit %h, required 0", section_limit_o);
        end
        reset_i = 1'b0;
        tick();
        vec++;
        if (byte_ready_o !== 1'b1) begin
            miscmp++;
            $display("FAIL reset_ready: got %b required 1", byte_ready_o);
        end
    endtask

    task automatic test_write_commit();
        do_frame(8'h01, 8'h05, 32'h12345678, 8'h00, "write5");
        vec++;
        if (coeff_bank_o[191:160] !== 32'h0) begin
            miscmp++;
            $display("FAIL write5_active: got %h required 0", coeff_bank_o[191:160]);
        end
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "commit");
        vec++;
        if (coeff_bank_o[191:160] !== 32'h12345678) begin
            miscmp++;
            $display("FAIL commit_active5: got %h required 12345678", coeff_bank_o[191:160]);
        end
        do_frame(8'h01, 8'd52, 32'hFFFABCDE, 8'h00, "write_limit");
        do_frame(8'h02, 8'hFF, 32'hDEADBEEF, 8'h00, "commit_limit");
    endtask

    task automatic test_errors();
        do_frame(8'h01, 8'h05, 32'h12345678, 8'h01, "bad_csum");
        do_frame(8'h01, 8'h35, 32'hCAFEF00D, 8'h00, "bad_addr");
        do_frame(8'h07, 8'h05, 32'hCAFEF00D, 8'h00, "bad_cmd");
        do_frame(8'h02, 8'h00, 32'h0, 8'h01, "bad_commit_csum");
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "commit_after_err");
    endtask

    task automatic test_inflight_commit();
        do_frame(8'h01, 8'd44, 32'hA5A55A5A, 8'h00, "write_mean1");
        engine_cycle(1, 0, "srdyi1");
        engine_cycle(1, 0, "srdyi2");
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "commit_busy");
        engine_cycle(0, 1, "drain1");
        engine_cycle(0, 1, "drain2");
        engine_cycle(1, 0, "defer_srdyi");
        engine_cycle(1, 1, "both");
        engine_cycle(0, 1, "drain3");
        engine_cycle(0, 0, "idle_copy");
        engine_cycle(0, 0, "idle_after");
    endtask

    task automatic test_inflight_sat();
        do_frame(8'h01, 8'd48, 32'h0BADCAFE, 8'h00, "write_std1");
        repeat (3) engine_cycle(0, 1, "floor");
        repeat (20) engine_cycle(1, 0, "fill");
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "commit_sat");
        for (int i = 0; i < 18; i++) engine_cycle(0, 1, "drain_sat");
    endtask

    task automatic test_timeout();
        int n;
        bit got;
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h05, 0);
        send_byte(8'h77, 0);
        send_byte(8'h66, 0);
        n = 0;
        got = 0;
        while (!got && n < TB_TIMEOUT + 20) begin
            tick();
            n++;
            if (ack_valid_o) got = 1;
        end
        vec++;
        if (!got || n < TB_TIMEOUT || n > TB_TIMEOUT + 2) begin
            miscmp++;
            $display("FAIL timeout_latency: got %0d cycles (seen=%0d) required about %0d",
                     n, got, TB_TIMEOUT);
        end
        vec++;
        if (ack_code_o !== 3'd4) begin
            miscmp++;
            $display("FAIL timeout_code: got %0d required 4", ack_code_o);
        end
        do_frame(8'h01, 8'h05, 32'h55AA1234, 8'h00, "after_tmo_write");
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "after_tmo_commit");
    endtask

    task automatic test_random();
        logic [7:0] cmd;
        logic [7:0] addr;
        logic [7:0] csx;
        int r;
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 9);
            addr = 8'($urandom_range(0, 52));
            csx = 8'h00;
            cmd = 8'h01;
            if (r == 6 || r == 7) cmd = 8'h02;
            if (r == 8) cmd = 8'($urandom_range(3, 255));
            if (r == 9) csx = 8'($urandom_range(1, 255));
            if (r == 5) addr = 8'($urandom_range(53, 255));
            do_frame(cmd, addr, $urandom, csx, "random");
        end
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "random_final_commit");
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h03, 0);
        test_reset();
        do_frame(8'h01, 8'h07, 32'h13579BDF, 8'h00, "pre_reset_write");
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "pre_reset_commit");
        engine_cycle(1, 0, "pre_reset_srdyi");
        do_frame(8'h01, 8'h08, 32'h2468ACE0, 8'h00, "pre_reset_write2");
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "pending_commit");
        vec++;
        if (commit_pending_o !== 1'b1) begin
            miscmp++;
            $display("FAIL pending_before_reset: got %b required 1", commit_pending_o);
        end
        test_reset();
        send_byte(8'h33, 0);
        do_frame(8'h01, 8'h09, 32'h0F0F0F0F, 8'h00, "post_reset_write");
        do_frame(8'h02, 8'h00, 32'h0, 8'h00, "post_reset_commit");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_write_commit();
        test_errors();
        test_inflight_commit();
        test_inflight_sat();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
